// File: rtl/branch_predictor_if.sv
// Purpose : Fetch/execute signal bundle between the pipeline and the branch predictor.
// Params  : DATA_WIDTH - PC/target width.
// Modports: master - pipeline side (drives lookup PC and resolve info, receives prediction)
//           slave  - predictor side (receives lookup PC and resolve info, drives prediction)
// Signals : PCF, PredTakenF, PredTargetF                      - fetch lookup
//           InstrValidE, CtrlE, JumpE, PCE, ActualTakenE,
//           ActualTargetE, PredTakenE, PredTargetE            - execute resolve
//           MispredictE, RedirectPCE                          - flush/redirect
interface branch_predictor_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] PCF;
  logic                  PredTakenF;
  logic [DATA_WIDTH-1:0] PredTargetF;
  logic                  InstrValidE;
  logic                  CtrlE;
  logic                  JumpE;
  logic [DATA_WIDTH-1:0] PCE;
  logic                  ActualTakenE;
  logic [DATA_WIDTH-1:0] ActualTargetE;
  logic                  PredTakenE;
  logic [DATA_WIDTH-1:0] PredTargetE;
  logic                  MispredictE;
  logic [DATA_WIDTH-1:0] RedirectPCE;

  modport master (
    output PCF, InstrValidE, CtrlE, JumpE, PCE, ActualTakenE, ActualTargetE,
           PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE
  );

  modport slave (
    input  PCF, InstrValidE, CtrlE, JumpE, PCE, ActualTakenE, ActualTargetE,
           PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE
  );
endinterface

// File: rtl/branch_predictor.sv
// Purpose : Dynamic branch predictor: direct-mapped BTB with saturating counters.
//           Fetch lookup is combinational; execute-stage resolves train the table
//           and produce the mispredict flag plus the corrected next PC.
// Ports   : clk, rst (async, active-high)
//           bp - branch_predictor_if.slave (fetch lookup, execute resolve, redirect)
//           BranchCount, MispredictCount - only with BP_PERF_COUNTERS_EN defined
// Option  : `define BP_PERF_COUNTERS_EN adds the two 32-bit performance counters.
module branch_predictor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned CTR_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predictor_if.slave    bp
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [31:0]          BranchCount,
  output logic [31:0]          MispredictCount
`endif
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = TAG_LO + TAG_WIDTH - 1;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;
  // Weakly-not-taken = 0111..., weakly-taken = 1000...
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [CTR_WIDTH-1:0] CTR_WT  = ~CTR_WNT;

  // BTB storage
  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_WIDTH-1:0]  r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];
  logic [CTR_WIDTH-1:0]  r_ctr    [ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0]      w_idx_f;
  logic [TAG_WIDTH-1:0]  w_tag_f;
  logic                  w_hit_f;
  logic                  w_pred_taken_f;
  logic [DATA_WIDTH-1:0] w_pc_plus4_f;

  assign w_idx_f        = bp.PCF[IDX_W+1:2];
  assign w_tag_f        = bp.PCF[TAG_HI:TAG_LO];
  assign w_hit_f        = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign w_pred_taken_f = w_hit_f && r_ctr[w_idx_f][CTR_WIDTH-1];
  assign w_pc_plus4_f   = bp.PCF + DATA_WIDTH'(4);

  assign bp.PredTakenF  = w_pred_taken_f;
  assign bp.PredTargetF = w_pred_taken_f ? r_target[w_idx_f] : w_pc_plus4_f;

  // Execute-side resolve
  logic [IDX_W-1:0]      w_idx_e;
  logic [TAG_WIDTH-1:0]  w_tag_e;
  logic                  w_hit_e;
  logic                  w_tag_match_e;
  logic                  w_act_taken_e;
  logic [DATA_WIDTH-1:0] w_pc_plus4_e;
  logic                  w_update;
  logic                  w_train;
  logic                  w_alloc;
  logic                  w_alias_clr;
  logic                  w_mispredict;
  logic [CTR_WIDTH-1:0]  w_ctr_cur;
  logic [CTR_WIDTH-1:0]  w_ctr_next;

  assign w_idx_e       = bp.PCE[IDX_W+1:2];
  assign w_tag_e       = bp.PCE[TAG_HI:TAG_LO];
  assign w_tag_match_e = (r_tag[w_idx_e] == w_tag_e);
  assign w_hit_e       = r_valid[w_idx_e] && w_tag_match_e;
  assign w_act_taken_e = bp.CtrlE && bp.ActualTakenE;
  assign w_pc_plus4_e  = bp.PCE + DATA_WIDTH'(4);

  assign w_update    = bp.InstrValidE && bp.CtrlE;
  assign w_train     = w_update && w_hit_e;
  assign w_alloc     = w_update && !w_hit_e && bp.ActualTakenE;
  // A non-control instruction that was predicted taken means a stale/aliased entry
  assign w_alias_clr = bp.InstrValidE && !bp.CtrlE && bp.PredTakenE && w_hit_e;

  // Wrong direction, or right (taken) direction with the wrong target
  assign w_mispredict = bp.InstrValidE &&
                        ((bp.PredTakenE != w_act_taken_e) ||
                         (bp.PredTakenE && w_act_taken_e &&
                          (bp.PredTargetE != bp.ActualTargetE)));

  assign bp.MispredictE = w_mispredict;
  assign bp.RedirectPCE = w_act_taken_e ? bp.ActualTargetE : w_pc_plus4_e;

  // Counter value written on train/allocate
  assign w_ctr_cur = r_ctr[w_idx_e];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (bp.JumpE) begin
      w_ctr_next = CTR_MAX;
    end else if (!w_hit_e) begin
      w_ctr_next = CTR_WT;
    end else if (bp.ActualTakenE) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_WIDTH'(1);
    end else begin
      if (w_ctr_cur != CTR_MIN) w_ctr_next = w_ctr_cur - CTR_WIDTH'(1);
    end
  end

  // Table update; reads above see the pre-update entry in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else begin
      if (w_train) begin
        r_ctr[w_idx_e] <= w_ctr_next;
        if (bp.ActualTakenE) r_target[w_idx_e] <= bp.ActualTargetE;
      end else if (w_alloc) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= bp.ActualTargetE;
        r_ctr[w_idx_e]    <= w_ctr_next;
      end else if (w_alias_clr) begin
        r_valid[w_idx_e]  <= 1'b0;
      end
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_update)     r_branch_count     <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign BranchCount     = r_branch_count;
  assign MispredictCount = r_mispredict_count;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Purpose : Directed self-checking bench for branch_predictor (default parameters:
//           32-bit PC, 16 entries, 8-bit tag, 2-bit counters).
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  branch_predictor_if #(.DATA_WIDTH(32)) bp_if ();

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  branch_predictor #(
    .DATA_WIDTH(32),
    .ENTRIES   (16),
    .TAG_WIDTH (8),
    .CTR_WIDTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bp             (bp_if.slave)
`ifdef BP_PERF_COUNTERS_EN
    ,
    .BranchCount    (branch_count),
    .MispredictCount(mispredict_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_e(input logic valid, input logic ctrl, input logic jump,
                         input logic [31:0] pce, input logic taken,
                         input logic [31:0] target, input logic ptaken,
                         input logic [31:0] ptarget);
    bp_if.InstrValidE   = valid;
    bp_if.CtrlE         = ctrl;
    bp_if.JumpE         = jump;
    bp_if.PCE           = pce;
    bp_if.ActualTakenE  = taken;
    bp_if.ActualTargetE = target;
    bp_if.PredTakenE    = ptaken;
    bp_if.PredTargetE   = ptarget;
  endtask

  task automatic idle_e();
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bp_if.PCF = 32'h100;
    idle_e();
    #2;
    chk("rst_pred_taken", 32'(bp_if.PredTakenF), 32'd0);
    chk("rst_pred_target", bp_if.PredTargetF, 32'h104);
    step();
    rst = 1'b0;

    // First taken resolve at 0x100 -> mispredict, allocate; lookup still sees old entry
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("first_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("first_redirect", bp_if.RedirectPCE, 32'h80);
    chk("same_cycle_old_entry", 32'(bp_if.PredTakenF), 32'd0);
    step();
    idle_e();
    #1;
    chk("alloc_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("alloc_pred_target", bp_if.PredTargetF, 32'h80);

    // Two more correctly-predicted taken resolves: ctr 2 -> 3 -> 3
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    chk("correct_pred_no_mispredict", 32'(bp_if.MispredictE), 32'd0);
    step();
    step();

    // Not-taken: mispredict, ctr 3 -> 2 still predicts taken
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("nt_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("nt_redirect", bp_if.RedirectPCE, 32'h104);
    step();
    idle_e();
    #1;
    chk("ctr2_still_taken", 32'(bp_if.PredTakenF), 32'd1);

    // Second not-taken: ctr 2 -> 1, now predicts not taken
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    idle_e();
    #1;
    chk("ctr1_not_taken", 32'(bp_if.PredTakenF), 32'd0);
    chk("ctr1_target_seq", bp_if.PredTargetF, 32'h104);

    // Retrain to ctr 2, then show aliasing PC 0x4100 hits the same entry
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    idle_e();
    bp_if.PCF = 32'h4100;
    #1;
    chk("alias_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("alias_pred_target", bp_if.PredTargetF, 32'h80);

    // Non-control at same index but different tag: no invalidation
    drive_e(1'b1, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    chk("other_tag_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("other_tag_redirect", bp_if.RedirectPCE, 32'h144);
    step();
    idle_e();
    bp_if.PCF = 32'h100;
    #1;
    chk("other_tag_kept", 32'(bp_if.PredTakenF), 32'd1);

    // Non-control at alias predicted taken: mispredict and invalidate
    drive_e(1'b1, 1'b0, 1'b0, 32'h4100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    chk("alias_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("alias_redirect", bp_if.RedirectPCE, 32'h4104);
    step();
    idle_e();
    #1;
    chk("alias_invalidated", 32'(bp_if.PredTakenF), 32'd0);

    // JAL at 0x40 -> 0x200 allocates with ctr all-ones
    drive_e(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    chk("jal_first_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("jal_first_redirect", bp_if.RedirectPCE, 32'h200);
    step();
    idle_e();
    bp_if.PCF = 32'h40;
    #1;
    chk("jal_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("jal_pred_target", bp_if.PredTargetF, 32'h200);
    drive_e(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    chk("jal_correct", 32'(bp_if.MispredictE), 32'd0);
    step();
    // One not-taken decrement from all-ones (3 -> 2) must still predict taken
    drive_e(1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    chk("jal_nt_redirect", bp_if.RedirectPCE, 32'h44);
    step();
    idle_e();
    #1;
    chk("jal_ctr_saturated", 32'(bp_if.PredTakenF), 32'd1);

    // Bubble never flags a mispredict
    drive_e(1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    chk("bubble_no_mispredict", 32'(bp_if.MispredictE), 32'd0);

    // Right direction, wrong target
    drive_e(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    chk("target_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("target_redirect", bp_if.RedirectPCE, 32'h300);
    idle_e();

    // PC+4 wraps at the top of the address space
    bp_if.PCF = 32'hFFFF_FFFC;
    drive_e(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8);
    #1;
    chk("wrap_pred_target", bp_if.PredTargetF, 32'h0);
    chk("wrap_redirect", bp_if.RedirectPCE, 32'h0);
    idle_e();

    // Reset mid-cycle with a trained entry being looked up
    bp_if.PCF = 32'h40;
    drive_e(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    step();
    #2;
    chk("pre_reset_taken", 32'(bp_if.PredTakenF), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_taken", 32'(bp_if.PredTakenF), 32'd0);
    chk("async_reset_target", bp_if.PredTargetF, 32'h44);
    idle_e();
    step();
    rst = 1'b0;
    #1;
    chk("post_reset_miss_40", 32'(bp_if.PredTakenF), 32'd0);
    bp_if.PCF = 32'h100;
    #1;
    chk("post_reset_miss_100", 32'(bp_if.PredTakenF), 32'd0);

`ifdef BP_PERF_COUNTERS_EN
    chk("perf_branch_zero", branch_count, 32'd0);
    chk("perf_mis_zero", mispredict_count, 32'd0);
    // 5 branches, mispredicts on the 1st and 5th
    drive_e(1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    drive_e(1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h80, 1'b1, 32'h80);
    step();
    step();
    drive_e(1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 32'h80, 1'b0, 32'h0);
    step();
    drive_e(1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    idle_e();
    chk("perf_branch_count", branch_count, 32'd5);
    chk("perf_mis_count", mispredict_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
